pu_feeder: RTL and testbench



---
 rtl/pu_feeder.sv | 182 ++++++++++++++++++
 tb/tb_pu_feeder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_feeder.sv
// pu_feeder: operand sequencer and result collector around one 4-input PU.
// Latency: N issue cycles + PU_LATENCY drain, then one done cycle. No backpressure; writes and start are dropped outside IDLE.
// Optional PU_FEEDER_CYCLE_CNT_EN adds the run_cycles busy-cycle counter output.
module pu_feeder #(
    parameter int NUM_NEURONS = 8,
    parameter int PU_LATENCY  = 2,
    parameter int DW          = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic                               wr_sel,
    input  logic [$clog2(NUM_NEURONS*4)-1:0]   wr_addr,
    input  logic [DW-1:0]                      wr_data,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [DW-1:0]                      pu_a1,
    output logic [DW-1:0]                      pu_a2,
    output logic [DW-1:0]                      pu_a3,
    output logic [DW-1:0]                      pu_a4,
    output logic [DW-1:0]                      pu_w1,
    output logic [DW-1:0]                      pu_w2,
    output logic [DW-1:0]                      pu_w3,
    output logic [DW-1:0]                      pu_w4,
    input  logic [DW-1:0]                      pu_out,
    input  logic [$clog2(NUM_NEURONS)-1:0]     rd_addr,
    output logic [DW-1:0]                      rd_data
`ifdef PU_FEEDER_CYCLE_CNT_EN
    ,
    output logic [15:0]                        run_cycles
`endif
);

    localparam int IW = $clog2(NUM_NEURONS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DW-1:0]         act_q  [4];
    logic [DW-1:0]         wgt_q  [NUM_NEURONS*4];
    logic [DW-1:0]         op_a_q [4];
    logic [DW-1:0]         op_w_q [4];
    logic [PU_LATENCY-1:0] vld_q;
    logic [PU_LATENCY-1:0] vld_d;
    logic [IW-1:0]         tag_q  [PU_LATENCY];
    logic [DW-1:0]         res_q  [NUM_NEURONS];

    logic issue;
    logic load_en;

    assign issue   = (state_q == S_ISSUE);
    assign load_en = wr_en && (state_q == S_IDLE);

    // Stage 0 holds the neuron issued last cycle; the last stage lines up with pu_out.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < PU_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Weight bank is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_en && wr_sel && (32'(wr_addr) < 32'(NUM_NEURONS * 4))) begin
            wgt_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                act_q[i]  <= '0;
                op_a_q[i] <= '0;
                op_w_q[i] <= '0;
            end
            for (int i = 0; i < PU_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            for (int i = 0; i < NUM_NEURONS; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            vld_q    <= vld_d;
            tag_q[0] <= idx_q;
            for (int i = 1; i < PU_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (vld_q[PU_LATENCY-1]) begin
                res_q[tag_q[PU_LATENCY-1]] <= pu_out;
            end
            if (load_en && !wr_sel) begin
                act_q[wr_addr[1:0]] <= wr_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ISSUE;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        for (int i = 0; i < 4; i++) begin
                            op_a_q[i] <= act_q[i];
                            op_w_q[i] <= wgt_q[{IW'(0), 2'(i)}];
                        end
                    end
                end
                S_ISSUE: begin
                    if (idx_q == IW'(NUM_NEURONS - 1)) begin
                        state_q <= S_DRAIN;
                        for (int i = 0; i < 4; i++) begin
                            op_a_q[i] <= '0;
                            op_w_q[i] <= '0;
                        end
                    end else begin
                        idx_q <= idx_q + IW'(1);
                        for (int i = 0; i < 4; i++) begin
                            op_w_q[i] <= wgt_q[{idx_q + IW'(1), 2'(i)}];
                        end
                    end
                end
                S_DRAIN: begin
                    if (vld_d == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PU_FEEDER_CYCLE_CNT_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            cyc_q <= '0;
        end else if (busy_q && (cyc_q != 16'hFFFF)) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign run_cycles = cyc_q;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign pu_a1   = op_a_q[0];
    assign pu_a2   = op_a_q[1];
    assign pu_a3   = op_a_q[2];
    assign pu_a4   = op_a_q[3];
    assign pu_w1   = op_w_q[0];
    assign pu_w2   = op_w_q[1];
    assign pu_w3   = op_w_q[2];
    assign pu_w4   = op_w_q[3];
    assign rd_data = res_q[rd_addr];

endmodule

// File: tb/tb_pu_feeder.sv
// Scoreboard bench for pu_feeder: expected operands queued at start, monitor checks every cycle.
module tb_pu_feeder;

    localparam int N  = 8;
    localparam int L  = 2;
    localparam int DW = 32;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          wr_sel  = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start   = 1'b0;
    logic [2:0]    rd_addr = '0;
    logic          busy, done;
    logic [DW-1:0] pu_a1, pu_a2, pu_a3, pu_a4;
    logic [DW-1:0] pu_w1, pu_w2, pu_w3, pu_w4;
    logic [DW-1:0] pu_out, rd_data;
`ifdef PU_FEEDER_CYCLE_CNT_EN
    logic [15:0]   run_cycles;
`endif

    pu_feeder #(.NUM_NEURONS(N), .PU_LATENCY(L), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done),
        .pu_a1(pu_a1), .pu_a2(pu_a2), .pu_a3(pu_a3), .pu_a4(pu_a4),
        .pu_w1(pu_w1), .pu_w2(pu_w2), .pu_w3(pu_w3), .pu_w4(pu_w4),
        .pu_out(pu_out), .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef PU_FEEDER_CYCLE_CNT_EN
        , .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]  w_m   [N][4];
    logic [DW-1:0]  a_m   [4];
    logic [DW-1:0]  res_m [N];
    logic [255:0]   exp_op_q [$];

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // Stand-in PU: mixes all eight lanes so a swapped or dropped lane changes the result.
    function automatic logic [31:0] pu_f(input logic [255:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = r ^ rotl(v[i*32 +: 32], i * 4);
        return r;
    endfunction

    function automatic logic [255:0] pack_k(input int k);
        return {w_m[k][3], w_m[k][2], w_m[k][1], w_m[k][0], a_m[3], a_m[2], a_m[1], a_m[0]};
    endfunction

    logic [31:0] pu_s1 = '0;
    logic [31:0] pu_s2 = '0;
    always @(posedge clk) begin
        pu_s1 <= pu_f({pu_w4, pu_w3, pu_w2, pu_w1, pu_a4, pu_a3, pu_a2, pu_a1});
        pu_s2 <= pu_s1;
    end
    assign pu_out = pu_s2;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: the first N busy cycles of a run must carry the queued operands, all others zero.
    logic [255:0] got_v;
    logic         mon_pb = 1'b0;
    int           k_iss  = 0;
    int           blen   = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pb = 1'b0;
            k_iss  = 0;
            blen   = 0;
        end else begin
            got_v = {pu_w4, pu_w3, pu_w2, pu_w1, pu_a4, pu_a3, pu_a2, pu_a1};
            if (busy && !mon_pb) begin
                k_iss = 0;
                blen  = 0;
            end
            if (busy) blen++;
            if (busy && k_iss < N) begin
                if (exp_op_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL op_unexpected: got operands %0h expected no issue", got_v);
                end else begin
                    chk("operands", got_v, exp_op_q.pop_front());
                end
                k_iss++;
            end else begin
                chk("operands_zero", got_v, '0);
            end
            chk("done_align", 256'(done), 256'(mon_pb && !busy));
            if (mon_pb && !busy) chk("busy_len", 256'(blen), 256'(N + L));
            mon_pb = busy;
        end
    end

    task automatic wr(input bit sel, input logic [4:0] addr, input logic [31:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel) w_m[addr >> 2][addr[1:0]] = data;
        else     a_m[addr[1:0]] = data;
    endtask

    task automatic load_random();
        for (int i = 0; i < 4; i++) wr(1'b0, {3'($urandom), 2'(i)}, $urandom);
        for (int i = 0; i < 4 * N; i++) wr(1'b1, 5'(i), $urandom);
    endtask

    task automatic push_run();
        for (int k = 0; k < N; k++) exp_op_q.push_back(pack_k(k));
    endtask

    task automatic kick();
        push_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 64 cycles");
        end
        // Writes and start during the done cycle must be dropped.
        if (ok && poke) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 5'd5; wr_data = $urandom; start = 1'b1;
        end
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        for (int k = 0; k < N; k++) res_m[k] = pu_f(pack_k(k));
`ifdef PU_FEEDER_CYCLE_CNT_EN
        chk("run_cycles", 256'(run_cycles), 256'(N + L));
`endif
    endtask

    task automatic check_results(input string name);
        for (int a = 0; a < N; a++) begin
            rd_addr = 3'(a);
            #1;
            chk(name, 256'(rd_data), 256'(res_m[a]));
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 256'(busy), '0);
        chk("rst_done", 256'(done), '0);
        chk("rst_ops", {pu_w4, pu_w3, pu_w2, pu_w1, pu_a4, pu_a3, pu_a2, pu_a1}, '0);
        for (int a = 0; a < N; a++) begin
            rd_addr = 3'(a);
            #1;
            chk("rst_rd_data", 256'(rd_data), '0);
        end
    endtask

    logic [31:0] dir_act [4];
    int          d_cnt, d_first, r2;
    logic        pb;

    initial begin
        for (int k = 0; k < N; k++) begin
            res_m[k] = '0;
            for (int j = 0; j < 4; j++) w_m[k][j] = '0;
        end
        for (int j = 0; j < 4; j++) a_m[j] = '0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'($urandom); wr_sel = 1'($urandom); wr_addr = 5'($urandom);
            wr_data = $urandom; start = 1'($urandom);
            @(posedge clk); #2;
        end
        check_reset_outputs();
        wr_en = 1'b0; start = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed latency and broadcast run.
        dir_act[0] = 32'h3F80_0000; dir_act[1] = 32'h4000_0000;
        dir_act[2] = 32'h4040_0000; dir_act[3] = 32'h4080_0000;
        for (int i = 0; i < 4; i++) wr(1'b0, 5'(i), dir_act[i]);
        for (int i = 0; i < 4 * N; i++)
            wr(1'b1, 5'(i), (i % 4 == 0) ? 32'h3F80_0000 + 32'(i / 4) : 32'h0);
        kick();
        wait_done(1'b0);
        check_results("res_directed");

        // Randomized runs; the second one also pokes writes/start into the done cycle.
        for (int r = 0; r < 3; r++) begin
            load_random();
            kick();
            wait_done(r == 1);
            check_results("res_random");
        end

        // Start and weight write in the middle of a run are ignored.
        kick();
        repeat (3) begin @(posedge clk); #1; end
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        wait_done(1'b0);
        repeat (5) begin @(posedge clk); #1; end
        chk("no_rerun", 256'(busy), '0);
        check_results("res_ignore1");
        kick();
        wait_done(1'b0);
        check_results("res_ignore2");

        // Reset in the middle of a run.
        kick();
        repeat (4) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        for (int j = 0; j < 4; j++) a_m[j] = '0;
        for (int k = 0; k < N; k++) res_m[k] = '0;
        exp_op_q.delete();
        @(negedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) wr(1'b0, 5'(i), $urandom);
        kick();
        wait_done(1'b0);
        check_results("res_after_rst");

        // Back-to-back runs with start held high.
        push_run();
        push_run();
        start = 1'b1;
        @(posedge clk);
        d_cnt = 0; d_first = -1; r2 = -1; pb = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (done) begin
                d_cnt++;
                if (d_first < 0) d_first = c;
            end
            if (busy && !pb && r2 < 0) r2 = c;
            pb = busy;
            if (c == 22) start = 1'b0;
        end
        @(posedge clk); #1;
        chk("b2b_dones", 256'(d_cnt), 256'(2));
        chk("b2b_gap", 256'(r2 - d_first), 256'(2));
        for (int k = 0; k < N; k++) res_m[k] = pu_f(pack_k(k));
        check_results("res_b2b");

        chk("op_q_drained", 256'(exp_op_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1);
    end

endmodule
